incr_pipe_unit: RTL and testbench

- Streaming 8-bit data-path stage: every clock it samples `data_in`, adds a fixed increment and presents the result on `data_out` after a fixed pipeline latency.
- No input handshake. `valid` flags that the pipeline has filled since reset, so `data_out` is meaningful.
- Sits as a simple always-flowing transform stage between upstream byte producers and downstream consumers. Also used as the reference block for tool-flow bring-up.

---
 rtl/incr_pipe_unit.sv | 58 +++++
 tb/tb_incr_pipe_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/incr_pipe_unit.sv
`default_nettype none
// ============================================================================
// incr_pipe_unit : streaming add-constant stage with configurable latency,
//                  optional saturation and a fill-tracking valid flag.
// Revision: 1.0
// ============================================================================
module incr_pipe_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int INCR        = 1,
  parameter int PIPE_STAGES = 1,
  parameter int SATURATE    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid
);

  localparam logic [DATA_WIDTH-1:0] C_INCR = DATA_WIDTH'(INCR);

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] stage1_d;
  logic [DATA_WIDTH-1:0] pipe_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_q;

  assign w_sum = {1'b0, data_in} + {1'b0, C_INCR};

  // Carry out of the full-width add selects the clamp in saturating builds.
  generate
    if (SATURATE != 0) begin : g_sat
      assign stage1_d = w_sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : w_sum[DATA_WIDTH-1:0];
    end else begin : g_wrap
      assign stage1_d = w_sum[DATA_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        pipe_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      pipe_q[0] <= stage1_d;
      vld_q[0]  <= 1'b1;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        pipe_q[i] <= pipe_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign data_out = pipe_q[PIPE_STAGES-1];
  assign valid    = vld_q[PIPE_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_incr_pipe_unit.sv
`default_nettype none
// ============================================================================
// tb_incr_pipe_unit : directed checks on default, saturating and 3-stage builds.
// Revision: 1.0
// ============================================================================
module tb_incr_pipe_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic [7:0] def_out, sat_out, lat_out;
  logic       def_vld, sat_vld, lat_vld;

  int n_cmp = 0;
  int n_err = 0;

  incr_pipe_unit u_def (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(def_out), .valid(def_vld)
  );

  incr_pipe_unit #(.SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(sat_out), .valid(sat_vld)
  );

  incr_pipe_unit #(.PIPE_STAGES(3)) u_lat (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(lat_out), .valid(lat_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    data_in = 8'hA5;

    // Reset hold
    step();
    step();
    check_eq("rst_def_out", def_out, 8'h00);
    check_eq("rst_def_vld", def_vld, 1'b0);
    check_eq("rst_sat_out", sat_out, 8'h00);
    check_eq("rst_lat_out", lat_out, 8'h00);
    check_eq("rst_lat_vld", lat_vld, 1'b0);

    // Fill and increment
    rst_n   = 1'b1;
    data_in = 8'h00;
    step();
    check_eq("fill_def_vld", def_vld, 1'b1);
    check_eq("fill_def_00", def_out, 8'h01);
    check_eq("fill_lat_vld1", lat_vld, 1'b0);
    data_in = 8'h10;
    step();
    check_eq("fill_def_10", def_out, 8'h11);
    check_eq("fill_lat_vld2", lat_vld, 1'b0);
    data_in = 8'h20;
    step();
    check_eq("fill_def_20", def_out, 8'h21);
    check_eq("fill_lat_vld3", lat_vld, 1'b1);
    check_eq("fill_lat_out", lat_out, 8'h01);

    // Wrap versus saturation
    data_in = 8'hFF;
    step();
    check_eq("wrap_def_ff", def_out, 8'h00);
    check_eq("wrap_def_vld", def_vld, 1'b1);
    check_eq("sat_ff", sat_out, 8'hFF);
    data_in = 8'hFE;
    step();
    check_eq("wrap_def_fe", def_out, 8'hFF);
    check_eq("sat_fe", sat_out, 8'hFF);
    data_in = 8'h7F;
    step();
    check_eq("sat_7f", sat_out, 8'h80);
    check_eq("wrap_def_7f", def_out, 8'h80);

    // Single 0x42 pulse through the 3-stage build
    data_in = 8'h00;
    step();
    data_in = 8'h42;
    step();
    data_in = 8'h00;
    step();
    check_eq("lat_pre", lat_out, 8'h01);
    step();
    check_eq("lat_pulse", lat_out, 8'h43);
    step();
    check_eq("lat_post", lat_out, 8'h01);

    // Mid-stream asynchronous reset
    for (int i = 0; i < 4; i++) begin
      data_in = 8'(8'h30 + i);
      step();
    end
    check_eq("pre_rst_def", def_out, 8'h34);
    check_eq("pre_rst_lat", lat_out, 8'h32);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_def_out", def_out, 8'h00);
    check_eq("async_def_vld", def_vld, 1'b0);
    check_eq("async_lat_out", lat_out, 8'h00);
    check_eq("async_lat_vld", lat_vld, 1'b0);
    #4;
    rst_n   = 1'b1;
    data_in = 8'h50;
    step();
    check_eq("refill_def_vld", def_vld, 1'b1);
    check_eq("refill_def_out", def_out, 8'h51);
    check_eq("refill_lat_vld1", lat_vld, 1'b0);
    check_eq("refill_lat_out1", lat_out, 8'h00);
    data_in = 8'h51;
    step();
    check_eq("refill_lat_vld2", lat_vld, 1'b0);
    check_eq("refill_lat_out2", lat_out, 8'h00);
    data_in = 8'h52;
    step();
    check_eq("refill_lat_vld3", lat_vld, 1'b1);
    check_eq("refill_lat_out3", lat_out, 8'h51);
    check_eq("refill_def_out3", def_out, 8'h53);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
